// File: rtl/deframer_pkg.sv
// Shared definitions for the receive deframer and the future transmit framer:
// framing constants and the deframer state encoding.
package deframer_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hA5;
    localparam logic [7:0] CRC_POLY = 8'h07;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        DRAIN   = 3'd4
    } state_t;

endpackage

// File: rtl/rx_deframer_if.sv
// Byte stream from rx into the deframer and payload stream out to the receive FIFO.
interface rx_deframer_if;

    // Input side is strobe-only: byte_in is sampled on any cycle with byte_valid high, there is
    // no back-pressure toward rx. Output side is strict valid/ready: a byte moves on a cycle
    // with m_valid & m_ready, and while m_valid & !m_ready, m_data and m_last hold steady.
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       reframe;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    modport master (
        input  byte_in,
        input  byte_valid,
        input  reframe,
        input  m_ready,
        output m_data,
        output m_valid,
        output m_last
    );

    modport slave (
        output byte_in,
        output byte_valid,
        output reframe,
        output m_ready,
        input  m_data,
        input  m_valid,
        input  m_last
    );

endinterface

// File: rtl/crc8_byte.sv
// One-byte CRC-8 update, MSB first, polynomial CRC_POLY; purely combinational.
module crc8_byte
    import deframer_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] d,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/rx_deframer.sv
// Hunts for SOF, buffers a length-prefixed payload, checks CRC-8 and replays only
// clean payloads to the receive FIFO; dropped frames are pulsed and counted.
module rx_deframer
    import deframer_pkg::*;
#(
    parameter int MAX_LEN = 64
) (
    input  logic          clk_sample,
    input  logic          rst,
    rx_deframer_if.master bus,
    output logic          pkt_ok,
    output logic          pkt_err,
    output logic          pkt_ovf,
    output logic [15:0]   err_count,
    output state_t        state_dbg
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] last_idx;
    logic [7:0]    crc_q;
    logic [7:0]    crc_seed;
    logic [7:0]    crc_next;
    logic          m_valid_q;
    logic [7:0]    mem [MAX_LEN];

    logic is_sof;
    logic len_bad;
    logic in_frame;
    logic drop;
    logic wr_en;
    logic xfer;

    // The LEN byte starts a fresh CRC; later bytes chain on the running value.
    assign crc_seed = (state == LEN) ? 8'h00 : crc_q;

    crc8_byte u_crc (
        .crc_in  (crc_seed),
        .d       (bus.byte_in),
        .crc_out (crc_next)
    );

    assign is_sof   = (bus.byte_in == SOF_BYTE);
    assign len_bad  = (bus.byte_in == 8'd0) || ({1'b0, bus.byte_in} > MAX_LEN_W);
    assign in_frame = (state == LEN) || (state == PAYLOAD) || (state == CHECK);
    assign drop     = in_frame &&
                      (bus.reframe ||
                       (bus.byte_valid && (((state == LEN) && len_bad) ||
                                           ((state == CHECK) && (bus.byte_in != crc_q)))));
    assign wr_en    = (state == PAYLOAD) && bus.byte_valid && !bus.reframe;
    assign xfer     = m_valid_q && bus.m_ready;

    always_ff @(posedge clk_sample) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.byte_in;
        end
    end

    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_idx  <= '0;
            crc_q     <= '0;
            m_valid_q <= 1'b0;
            pkt_ok    <= 1'b0;
            pkt_err   <= 1'b0;
            pkt_ovf   <= 1'b0;
        end else begin
            pkt_ok  <= 1'b0;
            pkt_err <= drop;
            pkt_ovf <= 1'b0;
            if (drop) begin
                state <= HUNT;
            end else begin
                case (state)
                    HUNT: begin
                        if (bus.byte_valid && !bus.reframe && is_sof) begin
                            state <= LEN;
                        end
                    end
                    LEN: begin
                        if (bus.byte_valid) begin
                            last_idx <= AW'(bus.byte_in - 8'd1);
                            wr_ptr   <= '0;
                            crc_q    <= crc_next;
                            state    <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        if (bus.byte_valid) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            crc_q  <= crc_next;
                            if (wr_ptr == last_idx) begin
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (bus.byte_valid) begin
                            state     <= DRAIN;
                            pkt_ok    <= 1'b1;
                            m_valid_q <= 1'b1;
                            rd_ptr    <= '0;
                        end
                    end
                    DRAIN: begin
                        // Bytes arriving now are lost; a SOF among them is flagged.
                        if (bus.byte_valid && is_sof) begin
                            pkt_ovf <= 1'b1;
                        end
                        if (xfer) begin
                            if (rd_ptr == last_idx) begin
                                state     <= HUNT;
                                m_valid_q <= 1'b0;
                                rd_ptr    <= '0;
                            end else begin
                                rd_ptr <= rd_ptr + 1'b1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (drop && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = mem[rd_ptr];
    assign bus.m_last  = m_valid_q && (rd_ptr == last_idx);
    assign state_dbg   = state;

endmodule

// File: tb/tb_rx_deframer.sv
// Bench for rx_deframer: table of fixed frames, hand-written corner sequences, then random
// frames checked against a polynomial-division CRC model and an expected-byte queue.
module tb_rx_deframer;
    import deframer_pkg::*;

    localparam int MAX_LEN = 64;
    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        int              n;
        logic [0:7][7:0] b;
        int              pay_at;
        int              d_ok;
        int              d_err;
    } vec_t;

    logic        clk_sample = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_ok;
    logic        pkt_err;
    logic        pkt_ovf;
    logic [15:0] err_count;
    state_t      state_dbg;

    rx_deframer_if bus ();

    rx_deframer #(.MAX_LEN(MAX_LEN)) dut (
        .clk_sample (clk_sample),
        .rst        (rst),
        .bus        (bus),
        .pkt_ok     (pkt_ok),
        .pkt_err    (pkt_err),
        .pkt_ovf    (pkt_ovf),
        .err_count  (err_count),
        .state_dbg  (state_dbg)
    );

    always #5 clk_sample = ~clk_sample;

    int total = 0;
    int bad = 0;
    int ok_seen = 0, err_seen = 0, ovf_seen = 0, xfer_seen = 0;
    int exp_ok = 0, exp_err = 0, exp_ovf = 0, exp_err_cnt = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sample);
        #1;
    endtask

    // CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1, bit by bit.
    function automatic logic [7:0] ref_crc(input byte_q_t msg);
        logic   bits[$];
        logic [8:0] rem;
        foreach (msg[k]) for (int i = 7; i >= 0; i--) bits.push_back(msg[k][i]);
        repeat (8) bits.push_back(1'b0);
        rem = '0;
        foreach (bits[j]) begin
            rem = {rem[7:0], bits[j]};
            if (rem[8]) rem = rem ^ 9'h107;
        end
        return rem[7:0];
    endfunction

    function automatic byte_q_t make_frame(input byte_q_t pay, input logic [7:0] crc_xor);
        byte_q_t body;
        byte_q_t f;
        body.push_back(8'(pay.size()));
        foreach (pay[i]) body.push_back(pay[i]);
        f.push_back(SOF_BYTE);
        foreach (body[i]) f.push_back(body[i]);
        f.push_back(ref_crc(body) ^ crc_xor);
        return f;
    endfunction

    function automatic byte_q_t rand_payload(input int len);
        byte_q_t p;
        for (int i = 0; i < len; i++) p.push_back(8'($urandom_range(0, 255)));
        return p;
    endfunction

    function automatic void expect_payload(input byte_q_t pay);
        foreach (pay[i]) exp_q.push_back({(i == pay.size() - 1), pay[i]});
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_bytes(input byte_q_t q, input bit gaps);
        foreach (q[i]) send_byte(q[i], gaps ? $urandom_range(0, 1) : 0);
    endtask

    // Runs the output side until m_valid drops; optional random ready and input noise.
    task automatic drain(input bit rnd_ready, input bit noise);
        int cyc;
        cyc = 0;
        while (bus.m_valid && cyc < 1000) begin
            bus.m_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (noise && $urandom_range(0, 3) == 0) begin
                bus.byte_valid = 1'b1;
                bus.byte_in    = $urandom_range(0, 1) ? SOF_BYTE : 8'h3C;
                if (bus.byte_in == SOF_BYTE) exp_ovf++;
            end
            tick();
            bus.byte_valid = 1'b0;
            cyc++;
        end
        bus.m_ready = 1'b0;
        check("drain_done", 32'(bus.m_valid), 32'd0);
    endtask

    // Output monitor: pulse counters, in-order payload check, hold-during-stall check.
    logic [7:0] hold_data;
    logic       hold_last;
    bit         stalled = 1'b0;
    logic [8:0] exp_v;

    always @(negedge clk_sample) begin
        if (pkt_ok === 1'b1) ok_seen++;
        if (pkt_err === 1'b1) err_seen++;
        if (pkt_ovf === 1'b1) ovf_seen++;
        if (bus.m_valid === 1'b1 && stalled) begin
            check("hold_data", 32'(bus.m_data), 32'(hold_data));
            check("hold_last", 32'(bus.m_last), 32'(hold_last));
        end
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            xfer_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_xfer: got=%0h want=none", {bus.m_last, bus.m_data});
            end else begin
                exp_v = exp_q.pop_front();
                check("xfer", 32'({bus.m_last, bus.m_data}), 32'(exp_v));
            end
        end
        stalled   = (bus.m_valid === 1'b1) && (bus.m_ready !== 1'b1);
        hold_data = bus.m_data;
        hold_last = bus.m_last;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    vec_t    vecs[6];
    byte_q_t pay;
    byte_q_t frm;
    int      ok0, err0, x0, nx, len, kind, k;
    logic    rp[5];

    initial begin
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        bus.reframe    = 1'b0;
        bus.m_ready    = 1'b0;

        vecs[0] = '{n:4, b:{8'hA5, 8'h01, 8'h42, 8'hDC, 32'h0}, pay_at:2, d_ok:1, d_err:0};
        vecs[1] = '{n:4, b:{8'hA5, 8'h01, 8'h42, 8'hDD, 32'h0}, pay_at:2, d_ok:0, d_err:1};
        vecs[2] = '{n:2, b:{8'hA5, 8'h00, 48'h0}, pay_at:2, d_ok:0, d_err:1};
        vecs[3] = '{n:2, b:{8'hA5, 8'h41, 48'h0}, pay_at:2, d_ok:0, d_err:1};
        vecs[4] = '{n:5, b:{8'h5A, 8'hA5, 8'h01, 8'h42, 8'hDC, 24'h0}, pay_at:3, d_ok:1, d_err:0};
        vecs[5] = '{n:2, b:{8'hA5, 8'hA5, 48'h0}, pay_at:2, d_ok:0, d_err:1};

        // Reset
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_state", 32'(state_dbg), 32'(HUNT));
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_last", 32'(bus.m_last), 32'd0);
        check("rst_pulses", 32'({pkt_ok, pkt_err, pkt_ovf}), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);

        // Fixed frame table
        for (int r = 0; r < 6; r++) begin
            ok0 = ok_seen; err0 = err_seen; x0 = xfer_seen; nx = 0;
            for (int i = 0; i < vecs[r].n; i++) send_byte(vecs[r].b[i], 0);
            if (vecs[r].d_ok != 0) begin
                len = int'(vecs[r].b[vecs[r].pay_at - 1]);
                for (int i = 0; i < len; i++)
                    exp_q.push_back({(i == len - 1), vecs[r].b[vecs[r].pay_at + i]});
                nx = len;
            end
            exp_ok += vecs[r].d_ok;
            exp_err += vecs[r].d_err;
            exp_err_cnt += vecs[r].d_err;
            drain(1'b0, 1'b0);
            tick(); tick();
            check($sformatf("vec%0d_ok", r), 32'(ok_seen - ok0), 32'(vecs[r].d_ok));
            check($sformatf("vec%0d_err", r), 32'(err_seen - err0), 32'(vecs[r].d_err));
            check($sformatf("vec%0d_xfers", r), 32'(xfer_seen - x0), 32'(nx));
            check($sformatf("vec%0d_err_count", r), 32'(err_count), 32'(exp_err_cnt));
            check($sformatf("vec%0d_state", r), 32'(state_dbg), 32'(HUNT));
        end

        // Backpressure: 11 22 33 with ready 1,0,0,1,1
        pay = '{8'h11, 8'h22, 8'h33};
        send_bytes(make_frame(pay, 8'h00), 1'b0);
        expect_payload(pay);
        exp_ok++;
        check("bp_first_valid", 32'(bus.m_valid), 32'd1);
        check("bp_first_data", 32'(bus.m_data), 32'h11);
        check("bp_first_last", 32'(bus.m_last), 32'd0);
        check("bp_pkt_ok", 32'(pkt_ok), 32'd1);
        rp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            bus.m_ready = rp[i];
            tick();
        end
        bus.m_ready = 1'b0;
        check("bp_done_valid", 32'(bus.m_valid), 32'd0);
        check("bp_done_state", 32'(state_dbg), 32'(HUNT));
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Maximum length frame
        pay = rand_payload(MAX_LEN);
        send_bytes(make_frame(pay, 8'h00), 1'b0);
        expect_payload(pay);
        exp_ok++;
        drain(1'b0, 1'b0);

        // Reframe after 2 of 4 payload bytes, then a clean frame
        ok0 = ok_seen; err0 = err_seen; x0 = xfer_seen;
        send_bytes('{SOF_BYTE, 8'h04, 8'h01, 8'h02}, 1'b0);
        bus.reframe = 1'b1;
        tick();
        bus.reframe = 1'b0;
        exp_err++; exp_err_cnt++;
        tick(); tick();
        check("reframe_err", 32'(err_seen - err0), 32'd1);
        check("reframe_no_out", 32'(xfer_seen - x0), 32'd0);
        check("reframe_state", 32'(state_dbg), 32'(HUNT));
        pay = '{8'h05, 8'h06};
        send_bytes(make_frame(pay, 8'h00), 1'b0);
        expect_payload(pay);
        exp_ok++;
        drain(1'b0, 1'b0);
        check("reframe_recover_ok", 32'(ok_seen - ok0), 32'd1);
        check("reframe_recover_xfers", 32'(xfer_seen - x0), 32'd2);

        // SOF during DRAIN, then a SOF right after the final transfer
        pay = '{8'hAA, 8'hBB};
        send_bytes(make_frame(pay, 8'h00), 1'b0);
        expect_payload(pay);
        exp_ok++;
        tick(); tick();
        send_byte(SOF_BYTE, 0);
        exp_ovf++;
        check("ovf_pulse", 32'(pkt_ovf), 32'd1);
        check("ovf_still_drain", 32'(state_dbg), 32'(DRAIN));
        drain(1'b0, 1'b0);
        pay = '{8'h42};
        send_bytes('{SOF_BYTE, 8'h01, 8'h42, 8'hDC}, 1'b0);
        expect_payload(pay);
        exp_ok++;
        check("b2b_pkt_ok", 32'(pkt_ok), 32'd1);
        drain(1'b0, 1'b0);

        // Reset in the middle of a drain
        pay = '{8'h01, 8'h02, 8'h03};
        send_bytes(make_frame(pay, 8'h00), 1'b0);
        exp_ok++;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'(HUNT));
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        exp_q.delete();
        exp_err_cnt = 0;
        tick();
        rst = 1'b0;
        bus.m_ready = 1'b1;
        x0 = xfer_seen;
        repeat (4) tick();
        bus.m_ready = 1'b0;
        check("post_rst_no_out", 32'(xfer_seen - x0), 32'd0);

        // Random frames
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 2)) begin
                k = $urandom_range(0, 255);
                send_byte((8'(k) == SOF_BYTE) ? 8'h00 : 8'(k), $urandom_range(0, 1));
            end
            kind = $urandom_range(0, 4);
            len = ($urandom_range(0, 7) == 0) ? MAX_LEN : $urandom_range(1, 12);
            pay = rand_payload(len);
            case (kind)
                0, 1: begin
                    send_bytes(make_frame(pay, 8'h00), 1'b1);
                    expect_payload(pay);
                    exp_ok++;
                    drain(1'b1, 1'b1);
                end
                2: begin
                    send_bytes(make_frame(pay, 8'($urandom_range(1, 255))), 1'b1);
                    exp_err++; exp_err_cnt++;
                end
                3: begin
                    send_byte(SOF_BYTE, 0);
                    send_byte($urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)), 0);
                    exp_err++; exp_err_cnt++;
                end
                default: begin
                    frm = make_frame(pay, 8'h00);
                    k = $urandom_range(0, len);
                    for (int i = 0; i < k + 2; i++) send_byte(frm[i], $urandom_range(0, 1));
                    bus.reframe    = 1'b1;
                    bus.byte_valid = 1'($urandom_range(0, 1));
                    bus.byte_in    = 8'($urandom_range(0, 255));
                    tick();
                    bus.reframe    = 1'b0;
                    bus.byte_valid = 1'b0;
                    exp_err++; exp_err_cnt++;
                end
            endcase
            tick(); tick();
            check("rand_err_count", 32'(err_count), 32'(exp_err_cnt));
        end

        tick(); tick();
        check("final_ok_pulses", 32'(ok_seen), 32'(exp_ok));
        check("final_err_pulses", 32'(err_seen), 32'(exp_err));
        check("final_ovf_pulses", 32'(ovf_seen), 32'(exp_ovf));
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_err_count", 32'(err_count), 32'(exp_err_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_deframer.md
# rx_deframer

Packet deframer sitting directly downstream of the `rx` byte recovery stage and upstream of the receive FIFO, in the `clk_sample` domain. It hunts for a start-of-frame byte, captures a length-prefixed payload into an internal buffer, and checks a CRC-8. Only CRC-clean payloads are replayed to the FIFO through a valid/ready stream; corrupt, truncated or oversized frames are dropped and counted.

## Interface
- `MAX_LEN`, 64: maximum payload bytes; buffer depth.
- `clk_sample` in 1: sample clock, the same clock as `rx`.
- `rst` in 1: asynchronous, active-high reset.
- `byte_in` in 8: byte from `rx`.
- `byte_valid` in 1: single-cycle strobe; `byte_in` is valid this cycle.
- `reframe` in 1: `rx` lost byte alignment.
- `m_data` out 8: payload byte to the FIFO.
- `m_valid` out 1: `m_data` is valid.
- `m_last` out 1: last payload byte of the frame.
- `m_ready` in 1: FIFO accepts the byte; a transfer occurs when `m_valid & m_ready`.
- `pkt_ok` out 1: one-cycle pulse when a frame passes CRC.
- `pkt_err` out 1: one-cycle pulse when a frame is dropped.
- `pkt_ovf` out 1: one-cycle pulse when a start-of-frame byte arrives during DRAIN.
- `err_count` out 16: saturating count of `pkt_err` pulses.

## Operation
- Frame format: SOF `0xA5`, LEN (1..MAX_LEN), LEN payload bytes, CRC.
- CRC: CRC-8, polynomial `0x07`, init `0x00`, MSB-first, no final XOR. It covers LEN and payload, not SOF.
- States:
  - HUNT: on a `byte_valid` strobe with `0xA5`, go to LEN. Other bytes are ignored.
  - LEN: if LEN is 0 or greater than MAX_LEN, pulse `pkt_err` and go to HUNT. Otherwise latch LEN, clear the write pointer, seed the CRC with LEN, and go to PAYLOAD.
  - PAYLOAD: write each byte to `buf[wr_ptr]`, increment the pointer and update the CRC. After the LENth byte, go to CHECK.
  - CHECK: on the next strobe, compare the received byte with the computed CRC. On a match, go to DRAIN with `pkt_ok` pulsing. On a mismatch, pulse `pkt_err` and go to HUNT.
  - DRAIN: `m_valid=1` and `m_data=buf[rd_ptr]`. `rd_ptr` increments on each transfer. `m_last = (rd_ptr == LEN-1)`. After the transfer with `m_last` set, go to HUNT.
- `reframe` in LEN, PAYLOAD or CHECK: pulse `pkt_err` and go to HUNT. `reframe` is ignored in HUNT and DRAIN.
- If `reframe` and `byte_valid` occur in the same cycle, `reframe` wins and the byte is discarded.
- During DRAIN, incoming bytes are discarded. A `0xA5` strobe pulses `pkt_ovf`; no hunting occurs until DRAIN completes.
- `err_count` increments on every `pkt_err` and holds at `0xFFFF`.
- The buffer is never read outside DRAIN. Its contents are undefined after reset and need no reset.

## Timing
- Reset values: state HUNT; `m_valid`, `m_last`, `pkt_ok`, `pkt_err`, `pkt_ovf` all 0; `err_count` 0; pointers 0.
- All state transitions and pulses are registered and take effect the cycle after the causing strobe.
- Latency: CRC strobe at cycle t gives `m_valid=1` and `pkt_ok=1` at t+1.
- `m_data` and `m_last` are held stable while `m_valid & !m_ready`.
- After the final transfer at cycle t, `m_valid=0` at t+1 and the state is HUNT. A SOF strobe at t+1 is accepted.
- Back-to-back transfers run at one byte per cycle when `m_ready` is held high.
- `rst` asserted mid-frame or mid-drain clears everything immediately. No partial frame reaches the FIFO after `rst` deasserts.

## Structure
- Shared package `deframer_pkg` holds:
  - `SOF_BYTE = 8'hA5` and `CRC_POLY = 8'h07`;
  - the state encoding (HUNT, LEN, PAYLOAD, CHECK, DRAIN).
- Sub-module `crc8_byte`: combinational CRC-8 update, taking `crc_in[7:0]` and `d[7:0]` and producing `crc_out[7:0]`. It is reused by the future tx framer.
- The buffer is a simple dual-port RAM, MAX_LEN×8, with asynchronous read (distributed RAM).

## Test plan
- Good frame: strobe A5 01 42 DC with `m_ready=1` -> single transfer `m_data=0x42`, `m_last=1`, `pkt_ok` pulse, `err_count=0`.
- Bad CRC: strobe A5 01 42 DD -> `pkt_err` pulse, no `m_valid`, `err_count=1`.
- Backpressure: strobe a 3-byte payload 11 22 33 with valid CRC and `m_ready` toggling 1,0,0,1,1 -> outputs 11, 22, 33 in order, values held during stalls, `m_last` only on 33.
- Length bounds: LEN=0, then LEN=65 with MAX_LEN=64 -> `pkt_err` pulse each time and a return to HUNT. The next SOF is accepted.
- Reframe mid-payload: `reframe` pulse after 2 of 4 payload bytes -> `pkt_err`, no output. A following clean frame is delivered.
- Overflow and reset: SOF during DRAIN -> `pkt_ovf` pulse and drain completes intact. `rst` during DRAIN -> `m_valid=0` immediately, state HUNT.
